// File: rtl/irq_req_latch_pkg.sv
// Shared definitions for the interrupt request latch: default widths, FSM
// encoding and the encoder-index to one-hot bit helper.
package irq_req_latch_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // The encoder counts from the MSB: index 0 is bit WIDTH-1, index WIDTH-1 is bit 0.
  function automatic logic [DEF_WIDTH-1:0] idx_to_onehot(input logic [DEF_IDX_W-1:0] idx);
    return DEF_WIDTH'(1) << (DEF_IDX_W'(DEF_WIDTH - 1) - idx);
  endfunction

endpackage

// File: rtl/irq_req_capture.sv
// Request capture: produces the per-cycle set vector for the pending register.
// IRQ_REQ_EDGE_EN selects rising-edge capture; otherwise requests are level-sensitive.
module irq_req_capture
  import irq_req_latch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
`ifdef IRQ_REQ_EDGE_EN
  input  logic             clock,
  input  logic             reset,
`endif
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] set
);

`ifdef IRQ_REQ_EDGE_EN
  logic [WIDTH-1:0] req_q;

  always_ff @(posedge clock) begin
    if (reset) req_q <= '0;
    else       req_q <= req;
  end

  assign set = req & ~req_q;
`else
  assign set = req;
`endif

endmodule

// File: rtl/irq_req_latch.sv
// Pending register plus snapshot FSM feeding the 8-bit priority encoder.
// Build option IRQ_REQ_EDGE_EN switches request capture to rising-edge mode.
module irq_req_latch
  import irq_req_latch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] ir_o,
  output logic             ir_valid_o,
  input  logic [IDX_W-1:0] state_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] pend_o
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;

  irq_req_capture #(.WIDTH(WIDTH)) u_capture (
`ifdef IRQ_REQ_EDGE_EN
    .clock (clock),
    .reset (reset),
`endif
    .req   (req_i),
    .set   (set)
  );

  // Acks only count while a snapshot is being presented.
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack_i) clr = idx_to_onehot(state_i);
  end

  // Set is OR-ed in after the clear so a same-cycle re-request keeps the bit pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= '0;
      ir_o       <= '0;
      ir_valid_o <= 1'b0;
      state      <= IDLE;
    end else begin
      pend <= (pend & ~clr) | set;
      case (state)
        IDLE: begin
          if ((pend & mask_i) != '0) begin
            ir_o       <= pend & mask_i;
            ir_valid_o <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_i) begin
            ir_valid_o <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pend_o = pend;

endmodule

// File: tb/tb_irq_req_latch.sv
// Self-checking bench for irq_req_latch: directed scenarios plus random traffic
// compared every cycle against a cycle-level behavioural model.
module tb_irq_req_latch;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic [7:0] ir_o;
  logic       ir_valid_o;
  logic [2:0] state_i;
  logic       ack_i;
  logic [7:0] pend_o;

  int nChecks = 0;
  int nFail   = 0;

  bit [7:0] mPend;
  bit [7:0] mIr;
  bit [7:0] mPrevReq;
  bit       mValid;
  int       mCool;

  irq_req_latch dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .ir_o       (ir_o),
    .ir_valid_o (ir_valid_o),
    .state_i    (state_i),
    .ack_i      (ack_i),
    .pend_o     (pend_o)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: after an accepted ack the snapshot stays empty for one cool-down
  // cycle, then the next cycle with anything enabled pending re-snapshots.
  task automatic modelEdge();
    bit [7:0] setVec;
    bit [7:0] clrVec;
    bit [7:0] oldPend;
    if (reset) begin
      mPend = 0; mIr = 0; mPrevReq = 0; mValid = 0; mCool = 0;
      return;
    end
`ifdef IRQ_REQ_EDGE_EN
    setVec = req_i & ~mPrevReq;
`else
    setVec = req_i;
`endif
    mPrevReq = req_i;
    oldPend  = mPend;
    clrVec   = (mValid && ack_i) ? (8'h01 << (7 - int'(state_i))) : 8'h00;
    mPend    = (mPend & ~clrVec) | setVec;
    if (mValid) begin
      if (ack_i) begin
        mValid = 0;
        mCool  = 1;
      end
    end else if (mCool > 0) begin
      mCool--;
    end else if ((oldPend & mask_i) != 0) begin
      mIr    = oldPend & mask_i;
      mValid = 1;
    end
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clock);
    #1;
    checkOutput("model_ir", ir_o, mIr);
    checkOutput("model_valid", {7'b0, ir_valid_o}, {7'b0, mValid});
    checkOutput("model_pend", pend_o, mPend);
  endtask

  task automatic doReset();
    reset = 1'b1; req_i = 8'h00; ack_i = 1'b0; state_i = 3'd0;
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    int presentations;
    logic prevValid;

    reset = 1'b1; req_i = 8'hFF; mask_i = 8'hFF; ack_i = 1'b0; state_i = 3'd0;
    #1;

    // Reset held two cycles with all requests high
    applyStimulus();
    applyStimulus();
    checkOutput("reset_pend", pend_o, 8'h00);
    checkOutput("reset_ir", ir_o, 8'h00);
    checkOutput("reset_valid", {7'b0, ir_valid_o}, 8'h00);
    reset = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("post_reset_ir", ir_o, 8'hFF);
    checkOutput("post_reset_valid", {7'b0, ir_valid_o}, 8'h01);

    // Single request presented two cycles later, then acked away
    doReset();
    req_i = 8'h02;
    applyStimulus();
    req_i = 8'h00;
    applyStimulus();
    checkOutput("single_ir", ir_o, 8'h02);
    checkOutput("single_valid", {7'b0, ir_valid_o}, 8'h01);
    state_i = 3'h6; ack_i = 1'b1;
    applyStimulus();
    ack_i = 1'b0;
    checkOutput("single_pend_cleared", pend_o, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput("single_valid_low", {7'b0, ir_valid_o}, 8'h00);
      applyStimulus();
    end

    // Snapshot frozen while presenting
    doReset();
    req_i = 8'h05;
    applyStimulus();
    req_i = 8'h00;
    applyStimulus();
    req_i = 8'h80;
    applyStimulus();
    req_i = 8'h00;
    applyStimulus();
    checkOutput("frozen_ir", ir_o, 8'h05);
    checkOutput("frozen_pend", pend_o, 8'h85);
    state_i = 3'h5; ack_i = 1'b1;
    applyStimulus();
    ack_i = 1'b0;
    checkOutput("frozen_drain_valid", {7'b0, ir_valid_o}, 8'h00);
    applyStimulus();
    applyStimulus();
    checkOutput("frozen_next_ir", ir_o, 8'h81);

    // Masked bits stay pending until the mask opens
    doReset();
    mask_i = 8'h0C; req_i = 8'h0F;
    applyStimulus();
    req_i = 8'h00;
    applyStimulus();
    checkOutput("mask_ir", ir_o, 8'h0C);
    state_i = 3'h4; ack_i = 1'b1;
    applyStimulus();
    ack_i = 1'b0; mask_i = 8'hFF;
    checkOutput("mask_pend", pend_o, 8'h07);
    applyStimulus();
    applyStimulus();
    checkOutput("mask_next_ir", ir_o, 8'h07);

    // Set wins over clear on the same bit
    doReset();
    req_i = 8'h80;
    applyStimulus();
    req_i = 8'h00;
    applyStimulus();
    state_i = 3'h0; ack_i = 1'b1; req_i = 8'h80;
    applyStimulus();
    ack_i = 1'b0; req_i = 8'h00;
    checkOutput("collide_pend", pend_o, 8'h80);
    applyStimulus();
    applyStimulus();
    checkOutput("collide_ir", ir_o, 8'h80);
    checkOutput("collide_valid", {7'b0, ir_valid_o}, 8'h01);

`ifdef IRQ_REQ_EDGE_EN
    // Held line posts exactly once in edge mode
    doReset();
    presentations = 0;
    prevValid = 1'b0;
    req_i = 8'h10;
    for (int i = 0; i < 10; i++) begin
      ack_i = (i == 3);
      state_i = 3'h3;
      applyStimulus();
      if (ir_valid_o && !prevValid) presentations++;
      prevValid = ir_valid_o;
    end
    ack_i = 1'b0;
    checkOutput("edge_pend", pend_o, 8'h00);
    checkOutput("edge_presentations", 8'(presentations), 8'h01);
    req_i = 8'h00;
`endif

    // Random traffic against the model, including ignored acks and mid-run resets
    doReset();
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      req_i   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 7) == 0) mask_i = 8'($urandom);
      ack_i   = ($urandom_range(0, 2) == 0);
      state_i = 3'($urandom);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/irq_req_latch.md
Name: irq_req_latch

Overview:
- Upstream feeder for the 8-bit casez priority encoder that maps `ir` to a 3-bit `state`.
- Collects request lines into a pending register, applies a mask, and presents a stable registered snapshot `ir_o` with a valid flag.
- On acknowledge, the encoder returns its 3-bit index, and this block clears the matching pending bit.
- Guarantees `ir_o` never changes while the downstream encoder is evaluating it.

Parameters:
- WIDTH, 8, number of request lines; must equal the encoder input width.
- IDX_W, 3, index width; equals clog2(WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  WIDTH  raw request lines.
- mask_i  input  WIDTH  1 = request enabled; sampled only at snapshot time.
- ir_o  output  WIDTH  registered masked snapshot; drives the encoder's `ir`.
- ir_valid_o  output  1  `ir_o` holds a nonzero snapshot.
- state_i  input  IDX_W  index returned by the encoder; 0 = MSB ... 6 = bit1, 7 = bit0.
- ack_i  input  1  encoder has consumed `ir_o`; `state_i` is valid in this cycle.
- pend_o  output  WIDTH  current pending register, unmasked, for debug.

Behaviour:
- Reset: pend=0, `ir_o`=0, `ir_valid_o`=0, FSM=IDLE. Reset applied mid-operation discards all pending and in-flight state in the same edge.
- Pending update, every cycle: pend_next = (pend & ~clr) | set.
  - clr is one-hot at bit WIDTH-1-`state_i` when an ack is accepted, else 0.
  - set comes from the request capture; see Optional Feature.
  - Set wins when set and clr hit the same bit in the same cycle: the bit stays pending.
- FSM states: IDLE, PRESENT, DRAIN.
  - IDLE: if (pend & `mask_i`) != 0, load `ir_o` <= pend & `mask_i`, set `ir_valid_o`=1, go to PRESENT. Otherwise stay; `ir_o` holds its last value with valid=0.
  - PRESENT: `ir_o` and `ir_valid_o` are frozen. New requests and mask changes affect pend only, never `ir_o`.
  - PRESENT exit: on `ack_i`=1, apply clr, drop `ir_valid_o` next edge, go to DRAIN.
  - DRAIN: one bubble cycle so the cleared pend is visible, then return to IDLE. Re-snapshot therefore happens in the following cycle.
- Ignored acks: `ack_i` in IDLE or DRAIN has no effect.
- Out-of-range index: an ack whose `state_i` maps to a bit not set in `ir_o` still clears that pend bit. This is not flagged.
- Latency, from IDLE: req asserted at cycle N -> pend bit set at N+1 -> `ir_valid_o`=1 at N+2.
- Ack-to-next-valid: ack at cycle M -> valid=0 at M+1 (DRAIN) -> valid=1 again at M+3 if pending remains.
- Masked bits: remain pending indefinitely and present once unmasked.
- Zero input: the encoder's all-zero index (7) is never requested, because valid requires a nonzero snapshot.

Optional Feature:
- Macro: IRQ_REQ_EDGE_EN.
- Defined: set = `req_i` & ~req_q, where req_q is a registered copy of `req_i` (reset 0). Only rising edges post a request; a held line posts once.
- Undefined: set = `req_i`, level-sensitive. A held line re-posts every cycle, so its bit is effectively never cleared while the line stays high.

Decomposition:
- Shared package holds:
  - the WIDTH and IDX_W defaults;
  - the FSM state encoding IDLE=2'd0, PRESENT=2'd1, DRAIN=2'd2;
  - an index-to-one-hot helper function (bit = WIDTH-1-idx).
- One natural sub-module: irq_req_capture, containing the set-vector logic and optional edge detector.
- The FSM and pending register stay in the top level.

Test Plan:
- Reset check: assert reset for 2 cycles with `req_i`=8'hFF -> pend=0, `ir_o`=0, `ir_valid_o`=0; 2 cycles after release (level build) `ir_o`=8'hFF, valid=1.
- Single request: `req_i`=8'h02 pulse at N, `mask_i`=8'hFF -> `ir_o`=8'h02, valid at N+2; ack with `state_i`=3'h6 -> pend=0, valid=0 and stays 0.
- Frozen snapshot: while PRESENT with `ir_o`=8'h05, raise req 8'h80 -> `ir_o` stays 8'h05; ack `state_i`=3'h5 -> after DRAIN `ir_o`=8'h81.
- Masking: pend=8'h0F, `mask_i`=8'h0C -> `ir_o`=8'h0C; ack idx 4 -> next `ir_o`=8'h07 after the mask is opened to 8'hFF.
- Set-wins collision: ack `state_i`=3'h0 in the same cycle `req_i`[7] pulses -> pend[7] remains 1, `ir_o` re-presents 8'h80.
- Edge mode (IRQ_REQ_EDGE_EN): hold `req_i`=8'h10 for 10 cycles, ack once -> pend=0 after the ack, exactly one valid presentation.
